// File: rtl/mips_multicycle_controller_pkg.sv
// mips_ctrl_pkg: shared types and encodings for the multicycle MIPS controller.
package mips_ctrl_pkg;
    localparam int OP_W    = 6;
    localparam int FUNCT_W = 6;
    localparam int STATE_W = 4;

    typedef enum logic [STATE_W-1:0] {
        S_FETCH    = 4'd0,
        S_DECODE   = 4'd1,
        S_MEMADR   = 4'd2,
        S_MEMRD    = 4'd3,
        S_MEMWB    = 4'd4,
        S_MEMWR    = 4'd5,
        S_EXECUTE  = 4'd6,
        S_ALUWB    = 4'd7,
        S_BRANCH   = 4'd8,
        S_ADDIEXEC = 4'd9,
        S_ADDIWB   = 4'd10,
        S_JUMP     = 4'd11
    } state_e;

    typedef enum logic [1:0] {
        ALUOP_ADD   = 2'b00,
        ALUOP_SUB   = 2'b01,
        ALUOP_FUNCT = 2'b10
    } aluop_e;

    localparam logic [OP_W-1:0] OP_RTYPE = 6'b000000;
    localparam logic [OP_W-1:0] OP_LW    = 6'b100011;
    localparam logic [OP_W-1:0] OP_SW    = 6'b101011;
    localparam logic [OP_W-1:0] OP_BEQ   = 6'b000100;
    localparam logic [OP_W-1:0] OP_ADDI  = 6'b001000;
    localparam logic [OP_W-1:0] OP_J     = 6'b000010;

    localparam logic [FUNCT_W-1:0] F_ADD = 6'b100000;
    localparam logic [FUNCT_W-1:0] F_SUB = 6'b100010;
    localparam logic [FUNCT_W-1:0] F_AND = 6'b100100;
    localparam logic [FUNCT_W-1:0] F_OR  = 6'b100101;
    localparam logic [FUNCT_W-1:0] F_SLT = 6'b101010;

    localparam logic [2:0] ALU_AND = 3'b000;
    localparam logic [2:0] ALU_OR  = 3'b001;
    localparam logic [2:0] ALU_ADD = 3'b010;
    localparam logic [2:0] ALU_SUB = 3'b110;
    localparam logic [2:0] ALU_SLT = 3'b111;
endpackage

// File: rtl/mips_multicycle_controller_if.sv
// mips_multicycle_controller_if: instruction fields in, datapath controls out.
interface mips_multicycle_controller_if;
    import mips_ctrl_pkg::*;
    logic [OP_W-1:0]    op;
    logic [FUNCT_W-1:0] funct;
    logic               zero;
    logic [2:0]         alu_control;
    logic               alu_src_a;
    logic [1:0]         alu_src_b;
    logic [1:0]         pc_src;
    logic               pc_en;
    logic               iord;
    logic               mem_write;
    logic               ir_write;
    logic               reg_dst;
    logic               mem_to_reg;
    logic               reg_write;
    logic               illegal;
    logic [STATE_W-1:0] state;

    modport master (
        input  op, funct, zero,
        output alu_control, alu_src_a, alu_src_b, pc_src, pc_en, iord, mem_write,
               ir_write, reg_dst, mem_to_reg, reg_write, illegal, state
    );
    modport slave (
        output op, funct, zero,
        input  alu_control, alu_src_a, alu_src_b, pc_src, pc_en, iord, mem_write,
               ir_write, reg_dst, mem_to_reg, reg_write, illegal, state
    );
endinterface

// File: rtl/mips_multicycle_controller_alu_decoder.sv
// alu_decoder: maps ALUOp and funct to the 3-bit ALU code; flags unknown R-type funct.
module alu_decoder
    import mips_ctrl_pkg::*;
(
    input  aluop_e             alu_op_i,
    input  logic [FUNCT_W-1:0] funct_i,
    output logic [2:0]         alu_control_o,
    output logic               funct_illegal_o
);
    always_comb begin
        alu_control_o   = ALU_ADD;
        funct_illegal_o = 1'b0;
        if (alu_op_i == ALUOP_SUB) alu_control_o = ALU_SUB;
        else if (alu_op_i == ALUOP_FUNCT) begin
            case (funct_i)
                F_ADD:   alu_control_o = ALU_ADD;
                F_SUB:   alu_control_o = ALU_SUB;
                F_AND:   alu_control_o = ALU_AND;
                F_OR:    alu_control_o = ALU_OR;
                F_SLT:   alu_control_o = ALU_SLT;
                default: funct_illegal_o = 1'b1;
            endcase
        end
    end
endmodule

// File: rtl/mips_multicycle_controller.sv
// mips_multicycle_controller: Moore FSM sequencing the multicycle MIPS datapath.
module mips_multicycle_controller
    import mips_ctrl_pkg::*;
(
    input  logic                         clk,
    input  logic                         rst_n,
    mips_multicycle_controller_if.master bus
);
    state_e state_q, state_d;
    aluop_e alu_op;
    logic   pc_write, branch, mem_write, ir_write, reg_write, illegal, funct_illegal;

    always_ff @(posedge clk) begin
        if (!rst_n) state_q <= S_FETCH;
        else        state_q <= state_d;
    end

    always_comb begin
        state_d        = S_FETCH;
        alu_op         = ALUOP_ADD;
        bus.alu_src_a  = 1'b0;
        bus.alu_src_b  = 2'b00;
        bus.pc_src     = 2'b00;
        bus.iord       = 1'b0;
        bus.reg_dst    = 1'b0;
        bus.mem_to_reg = 1'b0;
        pc_write       = 1'b0;
        branch         = 1'b0;
        mem_write      = 1'b0;
        ir_write       = 1'b0;
        reg_write      = 1'b0;
        illegal        = 1'b0;
        case (state_q)
            S_FETCH: begin
                bus.alu_src_b = 2'b01;
                ir_write      = 1'b1;
                pc_write      = 1'b1;
                state_d       = S_DECODE;
            end
            S_DECODE: begin
                bus.alu_src_b = 2'b11;
                case (bus.op)
                    OP_LW, OP_SW: state_d = S_MEMADR;
                    OP_RTYPE:     state_d = S_EXECUTE;
                    OP_BEQ:       state_d = S_BRANCH;
                    OP_ADDI:      state_d = S_ADDIEXEC;
                    OP_J:         state_d = S_JUMP;
                    default:      illegal = 1'b1;
                endcase
            end
            S_MEMADR: begin
                bus.alu_src_a = 1'b1;
                bus.alu_src_b = 2'b10;
                state_d       = (bus.op == OP_LW) ? S_MEMRD : S_MEMWR;
            end
            S_MEMRD: begin
                bus.iord = 1'b1;
                state_d  = S_MEMWB;
            end
            S_MEMWB: begin
                bus.mem_to_reg = 1'b1;
                reg_write      = 1'b1;
            end
            S_MEMWR: begin
                bus.iord  = 1'b1;
                mem_write = 1'b1;
            end
            S_EXECUTE: begin
                bus.alu_src_a = 1'b1;
                alu_op        = ALUOP_FUNCT;
                illegal       = funct_illegal;
                state_d       = funct_illegal ? S_FETCH : S_ALUWB;
            end
            S_ALUWB: begin
                bus.reg_dst = 1'b1;
                reg_write   = 1'b1;
            end
            S_BRANCH: begin
                bus.alu_src_a = 1'b1;
                alu_op        = ALUOP_SUB;
                bus.pc_src    = 2'b01;
                branch        = 1'b1;
            end
            S_ADDIEXEC: begin
                bus.alu_src_a = 1'b1;
                bus.alu_src_b = 2'b10;
                state_d       = S_ADDIWB;
            end
            S_ADDIWB: reg_write = 1'b1;
            S_JUMP: begin
                bus.pc_src = 2'b10;
                pc_write   = 1'b1;
            end
            // unreachable encodings look like FETCH but never write anything
            default: bus.alu_src_b = 2'b01;
        endcase
    end

    alu_decoder u_alu_decoder (
        .alu_op_i        (alu_op),
        .funct_i         (bus.funct),
        .alu_control_o   (bus.alu_control),
        .funct_illegal_o (funct_illegal)
    );

    assign bus.pc_en     = rst_n & (pc_write | (branch & bus.zero));
    assign bus.mem_write = rst_n & mem_write;
    assign bus.ir_write  = rst_n & ir_write;
    assign bus.reg_write = rst_n & reg_write;
    assign bus.illegal   = rst_n & illegal;
    assign bus.state     = state_q;
endmodule

// File: tb/tb_mips_multicycle_controller.sv
// tb_mips_multicycle_controller: directed checks of state walk and control outputs per opcode.
module tb_mips_multicycle_controller;
    logic clk = 1'b0;
    logic rst_n;
    int   errors = 0;
    int   checks = 0;

    mips_multicycle_controller_if bus ();

    mips_multicycle_controller dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [7:0] got, input logic [7:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        @(negedge clk);
    endtask

    logic [5:0] functs [5] = '{6'b100000, 6'b100010, 6'b100100, 6'b100101, 6'b101010};
    logic [2:0] codes  [5] = '{3'b010, 3'b110, 3'b000, 3'b001, 3'b111};

    initial begin
        rst_n = 1'b0;
        bus.op = 6'b000000;
        bus.funct = 6'b100000;
        bus.zero = 1'b0;
        tick();
        tick();
        check("rst_state", 8'(bus.state), 8'd0);
        check("rst_pc_en", 8'(bus.pc_en), 8'd0);
        check("rst_ir_write", 8'(bus.ir_write), 8'd0);
        rst_n = 1'b1;
        #1;
        check("fetch_ir_write", 8'(bus.ir_write), 8'd1);
        check("fetch_pc_en", 8'(bus.pc_en), 8'd1);
        check("fetch_alu", 8'(bus.alu_control), 8'h2);
        check("fetch_src_b", 8'(bus.alu_src_b), 8'h1);

        bus.op = 6'b100011;
        tick();
        check("lw_s1", 8'(bus.state), 8'd1);
        check("lw_dec_src_b", 8'(bus.alu_src_b), 8'h3);
        tick();
        check("lw_s2", 8'(bus.state), 8'd2);
        check("lw_adr_src_a", 8'(bus.alu_src_a), 8'd1);
        check("lw_adr_src_b", 8'(bus.alu_src_b), 8'h2);
        tick();
        check("lw_s3", 8'(bus.state), 8'd3);
        check("lw_rd_iord", 8'(bus.iord), 8'd1);
        check("lw_rd_reg_write", 8'(bus.reg_write), 8'd0);
        tick();
        check("lw_s4", 8'(bus.state), 8'd4);
        check("lw_wb_reg_write", 8'(bus.reg_write), 8'd1);
        check("lw_wb_mem_to_reg", 8'(bus.mem_to_reg), 8'd1);
        check("lw_wb_reg_dst", 8'(bus.reg_dst), 8'd0);
        tick();
        check("lw_s0", 8'(bus.state), 8'd0);

        tick();
        tick();
        tick();
        check("abort_in_memrd", 8'(bus.state), 8'd3);
        rst_n = 1'b0;
        #1;
        check("abort_pc_en", 8'(bus.pc_en), 8'd0);
        tick();
        tick();
        check("abort_state", 8'(bus.state), 8'd0);
        check("abort_ir_write", 8'(bus.ir_write), 8'd0);
        check("abort_reg_write", 8'(bus.reg_write), 8'd0);
        check("abort_mem_write", 8'(bus.mem_write), 8'd0);
        rst_n = 1'b1;
        #1;
        check("release_ir_write", 8'(bus.ir_write), 8'd1);
        check("release_pc_en", 8'(bus.pc_en), 8'd1);

        bus.op = 6'b000000;
        for (int i = 0; i < 5; i++) begin
            bus.funct = functs[i];
            tick();
            tick();
            check("r_exec_state", 8'(bus.state), 8'd6);
            check("r_exec_alu", 8'(bus.alu_control), 8'(codes[i]));
            check("r_exec_src_b", 8'(bus.alu_src_b), 8'h0);
            tick();
            check("r_wb_state", 8'(bus.state), 8'd7);
            check("r_wb_reg_write", 8'(bus.reg_write), 8'd1);
            check("r_wb_reg_dst", 8'(bus.reg_dst), 8'd1);
            tick();
        end

        bus.op = 6'b000100;
        bus.zero = 1'b1;
        tick();
        tick();
        check("beq_state", 8'(bus.state), 8'd8);
        check("beq_taken_pc_en", 8'(bus.pc_en), 8'd1);
        check("beq_pc_src", 8'(bus.pc_src), 8'h1);
        check("beq_alu", 8'(bus.alu_control), 8'h6);
        bus.zero = 1'b0;
        #1;
        check("beq_not_taken_pc_en", 8'(bus.pc_en), 8'd0);
        tick();
        check("beq_back", 8'(bus.state), 8'd0);

        bus.op = 6'b000010;
        tick();
        tick();
        check("j_state", 8'(bus.state), 8'd11);
        check("j_pc_en", 8'(bus.pc_en), 8'd1);
        check("j_pc_src", 8'(bus.pc_src), 8'h2);
        tick();
        check("j_back", 8'(bus.state), 8'd0);

        bus.op = 6'b101011;
        tick();
        tick();
        check("sw_adr_mem_write", 8'(bus.mem_write), 8'd0);
        tick();
        check("sw_state", 8'(bus.state), 8'd5);
        check("sw_mem_write", 8'(bus.mem_write), 8'd1);
        check("sw_iord", 8'(bus.iord), 8'd1);
        tick();
        check("sw_back", 8'(bus.state), 8'd0);
        check("sw_back_mem_write", 8'(bus.mem_write), 8'd0);

        bus.op = 6'b001000;
        tick();
        tick();
        check("addi_exec", 8'(bus.state), 8'd9);
        check("addi_src_b", 8'(bus.alu_src_b), 8'h2);
        tick();
        check("addi_wb", 8'(bus.state), 8'd10);
        check("addi_reg_write", 8'(bus.reg_write), 8'd1);
        check("addi_reg_dst", 8'(bus.reg_dst), 8'd0);
        tick();

        bus.op = 6'b111111;
        tick();
        check("illop_state", 8'(bus.state), 8'd1);
        check("illop_flag", 8'(bus.illegal), 8'd1);
        tick();
        check("illop_next", 8'(bus.state), 8'd0);
        check("illop_cleared", 8'(bus.illegal), 8'd0);

        bus.op = 6'b000000;
        bus.funct = 6'b000111;
        tick();
        check("illf_dec_flag", 8'(bus.illegal), 8'd0);
        tick();
        check("illf_state", 8'(bus.state), 8'd6);
        check("illf_flag", 8'(bus.illegal), 8'd1);
        check("illf_alu", 8'(bus.alu_control), 8'h2);
        tick();
        check("illf_next", 8'(bus.state), 8'd0);
        check("illf_reg_write", 8'(bus.reg_write), 8'd0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
